// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal)
// sharing one memory port for instruction and data, with a retired-instruction counter.
module multicycle_controller #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   funct7b5,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   mem_request,
  output logic                   mem_write,
  output logic                   address_select,
  output logic                   PC_write,
  output logic                   IR_write,
  output logic                   reg_write,
  output logic [1:0]             ALU_src_A,
  output logic [1:0]             ALU_src_B,
  output logic [2:0]             ALU_control,
  output logic [1:0]             immediate_select,
  output logic [1:0]             result_select,
  output logic                   retired,
  output logic [COUNT_WIDTH-1:0] retired_count,
  output logic                   trap,
  output logic [3:0]             dbg_state
);

  // Memory handshake: mem_request stays high until the cycle mem_ready is
  // sampled high; that cycle completes the access. mem_ready is ignored
  // whenever mem_request is low.

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ERROR
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [1:0]             w_alu_op;
  logic [2:0]             w_alu_funct;
  logic [1:0]             w_imm_sel;
  logic                   w_funct3_ok;

  assign dbg_state     = r_state;
  assign retired_count = r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (retired) r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // IR is stable after FETCH, so the immediate class decoded from it holds
  // for every later state of the instruction.
  always_comb begin
    w_imm_sel = 2'b00;
    case (opcode)
      OP_STORE: w_imm_sel = 2'b01;
      OP_BEQ:   w_imm_sel = 2'b10;
      OP_JAL:   w_imm_sel = 2'b11;
      default:  w_imm_sel = 2'b00;
    endcase
  end

  always_comb begin
    w_funct3_ok = 1'b0;
    w_alu_funct = 3'b000;
    case (funct3)
      3'b000: begin
        w_funct3_ok = 1'b1;
        w_alu_funct = (opcode[5] && funct7b5) ? 3'b001 : 3'b000;
      end
      3'b010: begin w_funct3_ok = 1'b1; w_alu_funct = 3'b101; end
      3'b110: begin w_funct3_ok = 1'b1; w_alu_funct = 3'b011; end
      3'b111: begin w_funct3_ok = 1'b1; w_alu_funct = 3'b010; end
      default: begin w_funct3_ok = 1'b0; w_alu_funct = 3'b000; end
    endcase
  end

  always_comb begin
    w_next_state     = r_state;
    mem_request      = 1'b0;
    mem_write        = 1'b0;
    address_select   = 1'b0;
    PC_write         = 1'b0;
    IR_write         = 1'b0;
    reg_write        = 1'b0;
    ALU_src_A        = 2'b00;
    ALU_src_B        = 2'b00;
    w_alu_op         = 2'b00;
    immediate_select = 2'b00;
    result_select    = 2'b00;
    retired          = 1'b0;
    trap             = 1'b0;
    ALU_control      = 3'b000;

    case (r_state)
      S_FETCH: begin
        mem_request   = 1'b1;
        ALU_src_B     = 2'b10;
        result_select = 2'b10;
        if (mem_ready) begin
          IR_write     = 1'b1;
          PC_write     = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALU_src_A        = 2'b01;
        ALU_src_B        = 2'b01;
        immediate_select = w_imm_sel;
        case (opcode)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE: w_next_state = w_funct3_ok ? S_EXECUTER : S_ERROR;
          OP_ITYPE: w_next_state = w_funct3_ok ? S_EXECUTEI : S_ERROR;
          OP_BEQ:   w_next_state = S_BEQ;
          OP_JAL:   w_next_state = S_JAL;
          default:  w_next_state = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALU_src_A        = 2'b10;
        ALU_src_B        = 2'b01;
        immediate_select = w_imm_sel;
        w_next_state     = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_request      = 1'b1;
        address_select   = 1'b1;
        immediate_select = w_imm_sel;
        if (mem_ready) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_select    = 2'b01;
        reg_write        = 1'b1;
        retired          = 1'b1;
        immediate_select = w_imm_sel;
        w_next_state     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_request      = 1'b1;
        mem_write        = 1'b1;
        address_select   = 1'b1;
        immediate_select = w_imm_sel;
        if (mem_ready) begin
          retired      = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_EXECUTER: begin
        ALU_src_A        = 2'b10;
        w_alu_op         = 2'b10;
        immediate_select = w_imm_sel;
        w_next_state     = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALU_src_A        = 2'b10;
        ALU_src_B        = 2'b01;
        w_alu_op         = 2'b10;
        immediate_select = w_imm_sel;
        w_next_state     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write        = 1'b1;
        retired          = 1'b1;
        immediate_select = w_imm_sel;
        w_next_state     = S_FETCH;
      end
      S_BEQ: begin
        ALU_src_A        = 2'b10;
        w_alu_op         = 2'b01;
        PC_write         = zero;
        retired          = 1'b1;
        immediate_select = w_imm_sel;
        w_next_state     = S_FETCH;
      end
      S_JAL: begin
        ALU_src_A        = 2'b01;
        ALU_src_B        = 2'b10;
        PC_write         = 1'b1;
        immediate_select = w_imm_sel;
        w_next_state     = S_ALUWB;
      end
      S_ERROR: trap = 1'b1;
      default: w_next_state = S_ERROR;
    endcase

    case (w_alu_op)
      2'b01:   ALU_control = 3'b001;
      2'b10:   ALU_control = w_alu_funct;
      default: ALU_control = 3'b000;
    endcase

    // Held reset silences every side effect, including an access in flight.
    if (!reset) begin
      mem_request = 1'b0;
      mem_write   = 1'b0;
      PC_write    = 1'b0;
      IR_write    = 1'b0;
      reg_write   = 1'b0;
      retired     = 1'b0;
      trap        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into
// a per-cycle expected control trace from its phase list and memory wait counts.
module tb_multicycle_controller;

  localparam int CW = 4;
  localparam int W  = 19;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          funct7b5 = 1'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_request, mem_write, address_select, PC_write, IR_write, reg_write;
  logic [1:0]    ALU_src_A, ALU_src_B, immediate_select, result_select;
  logic [2:0]    ALU_control;
  logic          retired, trap;
  logic [CW-1:0] retired_count;
  logic [3:0]    dbg_state;

  multicycle_controller #(.COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .mem_request(mem_request), .mem_write(mem_write),
    .address_select(address_select), .PC_write(PC_write), .IR_write(IR_write),
    .reg_write(reg_write), .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B),
    .ALU_control(ALU_control), .immediate_select(immediate_select),
    .result_select(result_select), .retired(retired),
    .retired_count(retired_count), .trap(trap), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [W-1:0]  exp_q[$];
  logic          rdy_q[$];
  logic [CW-1:0] exp_count = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Field order: req wr asel pcw irw rw ret trap | srcA srcB alu imm res
  function automatic logic [W-1:0] mk(input logic req, wr, asel, pcw, irw, rw, ret, trp,
                                      input logic [1:0] sa, sb, input logic [2:0] alu,
                                      input logic [1:0] imm, res);
    return {req, wr, asel, pcw, irw, rw, ret, trp, sa, sb, alu, imm, res};
  endfunction

  function automatic logic [W-1:0] observed();
    return {mem_request, mem_write, address_select, PC_write, IR_write, reg_write,
            retired, trap, ALU_src_A, ALU_src_B, ALU_control, immediate_select, result_select};
  endfunction

  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BEQ:   return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input int kind);
    case (kind)
      K_SW:    return 2'b01;
      K_BEQ:   return 2'b10;
      K_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ALU operation implied by an arithmetic instruction's funct fields.
  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  task automatic push(input logic rdy, input logic [W-1:0] v);
    rdy_q.push_back(rdy);
    exp_q.push_back(v);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic ph_fetch(input int fw);
    for (int i = 0; i <= fw; i++)
      push(i == fw, mk(1, 0, 0, i == fw, i == fw, 0, 0, 0, 2'd0, 2'd2, 3'd0, 2'd0, 2'd2));
  endtask

  // Drives each queued cycle and compares all controls mid-cycle.
  task automatic run_queue();
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clock);
      check("cyc", 32'(observed()), 32'(e));
      @(posedge clock);
      #1;
      if (e[12]) exp_count = exp_count + 1'b1;
    end
  endtask

  task automatic do_instr(input int kind, input logic [2:0] f3, input logic f7,
                          input logic z, input int fw, input int dw);
    logic [1:0] imm;
    logic [2:0] alu;
    imm = imm_of(kind);
    opcode = op_of(kind); funct3 = f3; funct7b5 = f7; zero = z;
    ph_fetch(fw);
    push(rnd_bit(), mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 3'd0, imm, 2'd0));
    case (kind)
      K_LW: begin
        push(rnd_bit(), mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 3'd0, imm, 2'd0));
        for (int i = 0; i <= dw; i++)
          push(i == dw, mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, imm, 2'd0));
        push(rnd_bit(), mk(0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 3'd0, imm, 2'd1));
      end
      K_SW: begin
        push(rnd_bit(), mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 3'd0, imm, 2'd0));
        for (int i = 0; i <= dw; i++)
          push(i == dw, mk(1, 1, 1, 0, 0, 0, i == dw, 0, 2'd0, 2'd0, 3'd0, imm, 2'd0));
      end
      K_R, K_I: begin
        alu = alu_of(f3, f7, kind == K_R);
        push(rnd_bit(), mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, (kind == K_I) ? 2'd1 : 2'd0,
                           alu, imm, 2'd0));
        push(rnd_bit(), mk(0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 3'd0, imm, 2'd0));
      end
      K_BEQ:
        push(rnd_bit(), mk(0, 0, 0, z, 0, 0, 1, 0, 2'd2, 2'd0, 3'd1, imm, 2'd0));
      default: begin
        push(rnd_bit(), mk(0, 0, 0, 1, 0, 0, 0, 0, 2'd1, 2'd2, 3'd0, imm, 2'd0));
        push(rnd_bit(), mk(0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 3'd0, imm, 2'd0));
      end
    endcase
    run_queue();
    check("count", 32'(retired_count), 32'(exp_count));
  endtask

  // Unsupported encoding: DECODE then a trap that persists with no side effects.
  task automatic do_bad(input logic [6:0] op, input logic [2:0] f3);
    opcode = op; funct3 = f3; funct7b5 = rnd_bit(); zero = rnd_bit();
    ph_fetch(0);
    push(rnd_bit(), mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 3'd0, 2'd0, 2'd0));
    for (int i = 0; i < 6; i++)
      push(rnd_bit(), mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0));
    run_queue();
    check("trap_count", 32'(retired_count), 32'(exp_count));
  endtask

  // Called #1 after a rising edge; holds reset across one edge and releases it.
  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clock);
    check("rst_req", 32'(mem_request), 32'd0);
    check("rst_en", 32'({PC_write, IR_write, reg_write, mem_write, retired, trap}), 32'd0);
    check("rst_cnt", 32'(retired_count), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_count = '0;
    mem_ready = 1'b0;
    @(negedge clock);
    check("post_rst_req", 32'(mem_request), 32'd1);
    check("post_rst_asel", 32'(address_select), 32'd0);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] legal_f3();
    case ($urandom_range(0, 3))
      0:       return 3'b000;
      1:       return 3'b010;
      2:       return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // addi, add, sw, lw with no wait states.
    do_instr(K_I, 3'b000, 1'b0, 1'b0, 0, 0);
    do_instr(K_R, 3'b000, 1'b0, 1'b0, 0, 0);
    do_instr(K_SW, 3'b010, 1'b0, 1'b0, 0, 0);
    do_instr(K_LW, 3'b010, 1'b0, 1'b0, 0, 0);
    check("seq_count", 32'(retired_count), 32'd4);

    do_instr(K_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    do_instr(K_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    do_instr(K_R, 3'b110, 1'b0, 1'b0, 3, 0);
    do_instr(K_R, 3'b000, 1'b1, 1'b0, 0, 0);
    do_instr(K_I, 3'b000, 1'b1, 1'b0, 0, 0);
    do_instr(K_R, 3'b111, 1'b0, 1'b0, 0, 0);
    do_instr(K_JAL, 3'b000, 1'b0, 1'b0, 1, 0);
    do_instr(K_LW, 3'b010, 1'b0, 1'b0, 2, 3);
    do_instr(K_SW, 3'b010, 1'b0, 1'b0, 1, 2);

    do_bad(7'b0110011, 3'b001);
    do_reset();
    do_bad(7'b0110111, 3'b000);
    do_reset();

    // Abandon a stalled load by resetting during its data access.
    do_instr(K_R, 3'b010, 1'b0, 1'b0, 0, 0);
    opcode = op_of(K_LW); funct3 = 3'b010;
    ph_fetch(0);
    push(rnd_bit(), mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 3'd0, 2'd0, 2'd0));
    push(rnd_bit(), mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 3'd0, 2'd0, 2'd0));
    push(1'b0, mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0));
    run_queue();
    do_reset();

    // Counter wrap: 15 instructions reach all-ones, the 16th returns to zero.
    for (int i = 0; i < 15; i++)
      do_instr($urandom_range(K_LW, K_JAL), legal_f3(), rnd_bit(), rnd_bit(),
               $urandom_range(0, 1), $urandom_range(0, 1));
    check("count_max", 32'(retired_count), 32'hF);
    do_instr(K_BEQ, 3'b000, 1'b0, rnd_bit(), 0, 0);
    check("count_wrap", 32'(retired_count), 32'd0);

    for (int i = 0; i < 40; i++)
      do_instr($urandom_range(K_LW, K_JAL), legal_f3(), rnd_bit(), rnd_bit(),
               $urandom_range(0, 2), $urandom_range(0, 2));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
